// File: rtl/memory_responder.sv
// Dual-port (instruction read / data read-write) word memory with fixed ack latency.
// Each port runs its own IDLE/BUSY/ACK handshake; a backdoor load path preloads the array.
module memory_responder #(
   parameter int LATENCY   = 2,
   parameter int ADDR_BITS = 8
) (
   input  logic        Clk,
   input  logic        Reset_N,
   input  logic        i_readM,
   input  logic [15:0] i_address,
   inout  wire  [15:0] i_data,
   output logic        i_ack,
   input  logic        d_readM,
   input  logic        d_writeM,
   input  logic [15:0] d_address,
   inout  wire  [15:0] d_data,
   output logic        d_ack,
   input  logic        ld_en,
   input  logic [15:0] ld_addr,
   input  logic [15:0] ld_data
);

   localparam int         CW       = 4;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   logic [15:0] mem_q [2**ADDR_BITS];

   // ---------------- instruction port ----------------
   state_e                 i_state_q, i_state_d;
   logic [CW-1:0]          i_cnt_q, i_cnt_d;
   logic [ADDR_BITS-1:0]   i_addr_q, i_addr_d;
   logic [15:0]            i_rdata_q;
   logic                   i_fire;

   always_comb begin
      i_state_d = i_state_q;
      i_cnt_d   = i_cnt_q;
      i_addr_d  = i_addr_q;
      i_fire    = 1'b0;
      unique case (i_state_q)
         ST_IDLE: begin
            if (i_readM) begin
               i_addr_d  = i_address[ADDR_BITS-1:0];
               i_cnt_d   = CNT_INIT;
               i_state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!i_readM) begin
               i_cnt_d   = '0;
               i_state_d = ST_IDLE;
            end else if (i_cnt_q == '0) begin
               i_fire    = 1'b1;
               i_state_d = ST_ACK;
            end else begin
               i_cnt_d   = i_cnt_q - 1'b1;
            end
         end
         ST_ACK:  i_state_d = ST_IDLE;
         default: i_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset_N) begin
      if (Reset_N) begin
         i_state_q <= ST_IDLE;
         i_cnt_q   <= '0;
         i_addr_q  <= '0;
         i_rdata_q <= '0;
      end else begin
         i_state_q <= i_state_d;
         i_cnt_q   <= i_cnt_d;
         i_addr_q  <= i_addr_d;
         // Reads the pre-commit word, so a same-edge data write is not visible here
         if (i_fire) i_rdata_q <= mem_q[i_addr_q];
      end
   end

   assign i_ack  = (i_state_q == ST_ACK);
   assign i_data = i_ack ? i_rdata_q : {16{1'bz}};

   // ---------------- data port ----------------
   state_e                 d_state_q, d_state_d;
   logic [CW-1:0]          d_cnt_q, d_cnt_d;
   logic [ADDR_BITS-1:0]   d_addr_q, d_addr_d;
   logic [15:0]            d_wdata_q, d_wdata_d;
   logic [15:0]            d_rdata_q;
   logic                   d_wr_q, d_wr_d;
   logic                   d_fire, d_commit, d_req_held;

   // Abort watches only the request type that was latched at sample time
   assign d_req_held = d_wr_q ? d_writeM : d_readM;

   always_comb begin
      d_state_d = d_state_q;
      d_cnt_d   = d_cnt_q;
      d_addr_d  = d_addr_q;
      d_wdata_d = d_wdata_q;
      d_wr_d    = d_wr_q;
      d_fire    = 1'b0;
      unique case (d_state_q)
         ST_IDLE: begin
            if (d_readM || d_writeM) begin
               d_addr_d  = d_address[ADDR_BITS-1:0];
               d_wr_d    = d_writeM;
               d_cnt_d   = CNT_INIT;
               d_state_d = ST_BUSY;
               if (d_writeM) d_wdata_d = d_data;
            end
         end
         ST_BUSY: begin
            if (!d_req_held) begin
               d_cnt_d   = '0;
               d_state_d = ST_IDLE;
            end else if (d_cnt_q == '0) begin
               d_fire    = 1'b1;
               d_state_d = ST_ACK;
            end else begin
               d_cnt_d   = d_cnt_q - 1'b1;
            end
         end
         ST_ACK:  d_state_d = ST_IDLE;
         default: d_state_d = ST_IDLE;
      endcase
   end

   assign d_commit = d_fire & d_wr_q;

   always_ff @(posedge Clk or posedge Reset_N) begin
      if (Reset_N) begin
         d_state_q <= ST_IDLE;
         d_cnt_q   <= '0;
         d_addr_q  <= '0;
         d_wdata_q <= '0;
         d_wr_q    <= 1'b0;
         d_rdata_q <= '0;
      end else begin
         d_state_q <= d_state_d;
         d_cnt_q   <= d_cnt_d;
         d_addr_q  <= d_addr_d;
         d_wdata_q <= d_wdata_d;
         d_wr_q    <= d_wr_d;
         if (d_fire && !d_wr_q) d_rdata_q <= mem_q[d_addr_q];
      end
   end

   assign d_ack  = (d_state_q == ST_ACK);
   assign d_data = (d_ack && !d_wr_q) ? d_rdata_q : {16{1'bz}};

   // ---------------- array ----------------
   // No reset: contents survive Reset_N. Data-port commit is last so it wins a collision.
   always_ff @(posedge Clk) begin
      if (ld_en)    mem_q[ld_addr[ADDR_BITS-1:0]] <= ld_data;
      if (d_commit) mem_q[d_addr_q]               <= d_wdata_q;
   end

   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_address[15:ADDR_BITS], d_address[15:ADDR_BITS],
                               ld_addr[15:ADDR_BITS]};

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (LATENCY=2, ADDR_BITS=8); undriven buses read as 0xFFFF.
module tb_memory_responder;
   localparam int L  = 2;
   localparam logic [15:0] HIZ = 16'hFFFF;

   logic        Clk = 1'b0;
   logic        Reset_N;
   logic        i_readM, d_readM, d_writeM, ld_en;
   logic [15:0] i_address, d_address, ld_addr, ld_data;
   logic        i_ack, d_ack;
   wire  [15:0] i_bus, d_bus;
   logic        d_drv_en;
   logic [15:0] d_drv;

   int n_checks = 0;
   int n_errors = 0;

   assign d_bus = d_drv_en ? d_drv : {16{1'bz}};

   for (genvar b = 0; b < 16; b++) begin : g_pu
      pullup (i_bus[b]);
      pullup (d_bus[b]);
   end

   always #5 Clk = ~Clk;

   memory_responder #(.LATENCY(L), .ADDR_BITS(8)) dut (
      .Clk(Clk), .Reset_N(Reset_N),
      .i_readM(i_readM), .i_address(i_address), .i_data(i_bus), .i_ack(i_ack),
      .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_bus),
      .d_ack(d_ack),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] v);
      ld_en = 1'b1; ld_addr = a; ld_data = v;
      @(negedge Clk);
      ld_en = 1'b0;
   endtask

   // Call at a negedge; the following posedge samples the request.
   task automatic i_read_chk(input logic [15:0] a, input logic [15:0] exp);
      i_readM = 1'b1; i_address = a;
      for (int c = 1; c <= L + 1; c++) begin
         @(negedge Clk); #1;
         chk("i_ack", i_ack, (c == L + 1));
         chk("i_data", i_bus, (c == L + 1) ? exp : HIZ);
      end
      i_readM = 1'b0;
      @(negedge Clk); #1;
      chk("i_ack_end", i_ack, 1'b0);
      chk("i_data_end", i_bus, HIZ);
   endtask

   task automatic d_txn(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wv, input logic [15:0] exp);
      d_readM = rd; d_writeM = wr; d_address = a;
      d_drv = wv; d_drv_en = wr;
      for (int c = 1; c <= L + 1; c++) begin
         @(negedge Clk);
         if (c == 1) d_drv_en = 1'b0;
         #1;
         chk("d_ack", d_ack, (c == L + 1));
         chk("d_data", d_bus, (c == L + 1 && !wr) ? exp : HIZ);
      end
      d_readM = 1'b0; d_writeM = 1'b0;
      @(negedge Clk); #1;
      chk("d_ack_end", d_ack, 1'b0);
      chk("d_data_end", d_bus, HIZ);
   endtask

   initial begin
      Reset_N = 1'b1;
      i_readM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0; ld_en = 1'b0;
      i_address = '0; d_address = '0; ld_addr = '0; ld_data = '0;
      d_drv_en = 1'b0; d_drv = '0;
      #1;
      chk("rst_i_ack", i_ack, 1'b0);
      chk("rst_d_ack", d_ack, 1'b0);
      chk("rst_i_data", i_bus, HIZ);
      chk("rst_d_data", d_bus, HIZ);
      repeat (2) @(negedge Clk);
      Reset_N = 1'b0;

      preload(16'h0010, 16'hBEEF);
      preload(16'h0030, 16'hAAAA);
      preload(16'h0040, 16'h7777);

      // instruction read, then aliased address with upper bits set
      i_read_chk(16'h0010, 16'hBEEF);
      i_read_chk(16'h0110, 16'hBEEF);

      // write then read back
      d_txn(1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000);
      d_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234);

      // same-edge data write and instruction read to one address
      i_readM = 1'b1; i_address = 16'h0030;
      d_writeM = 1'b1; d_address = 16'h0030; d_drv = 16'h5555; d_drv_en = 1'b1;
      for (int c = 1; c <= L + 1; c++) begin
         @(negedge Clk);
         if (c == 1) d_drv_en = 1'b0;
         #1;
         chk("sim_i_ack", i_ack, (c == L + 1));
         chk("sim_d_ack", d_ack, (c == L + 1));
         if (c == L + 1) begin
            chk("sim_i_data", i_bus, 16'hAAAA);
            chk("sim_d_data", d_bus, HIZ);
         end
      end
      i_readM = 1'b0; d_writeM = 1'b0;
      @(negedge Clk);
      i_read_chk(16'h0030, 16'h5555);

      // write dropped while BUSY: aborted, no ack, array unchanged
      d_writeM = 1'b1; d_address = 16'h0040; d_drv = 16'h9999; d_drv_en = 1'b1;
      @(negedge Clk);
      d_writeM = 1'b0; d_drv_en = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk); #1;
         chk("abort_d_ack", d_ack, 1'b0);
      end
      d_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h7777);

      // read+write together is a write; bus stays undriven at ack
      d_txn(1'b1, 1'b1, 16'h0050, 16'h0F0F, 16'h0000);
      d_txn(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0F0F);

      // backdoor load colliding with data commit: data port wins
      d_writeM = 1'b1; d_address = 16'h0060; d_drv = 16'h2222; d_drv_en = 1'b1;
      @(negedge Clk);
      d_drv_en = 1'b0;
      @(negedge Clk);
      ld_en = 1'b1; ld_addr = 16'h0060; ld_data = 16'h3333;
      @(negedge Clk); #1;
      chk("col_d_ack", d_ack, 1'b1);
      ld_en = 1'b0; d_writeM = 1'b0;
      @(negedge Clk);
      d_txn(1'b1, 1'b0, 16'h0060, 16'h0000, 16'h2222);

      // reset mid-BUSY discards the in-flight write
      i_readM = 1'b1; i_address = 16'h0030;
      d_writeM = 1'b1; d_address = 16'h0010; d_drv = 16'h4444; d_drv_en = 1'b1;
      @(negedge Clk);
      d_drv_en = 1'b0;
      @(negedge Clk);
      Reset_N = 1'b1;
      #1;
      chk("rb_i_ack", i_ack, 1'b0);
      chk("rb_d_ack", d_ack, 1'b0);
      chk("rb_i_data", i_bus, HIZ);
      chk("rb_d_data", d_bus, HIZ);
      @(negedge Clk);
      i_readM = 1'b0; d_writeM = 1'b0;
      // request present at the first edge after release
      Reset_N = 1'b0;
      i_read_chk(16'h0010, 16'hBEEF);

      // reset during ACK clears ack and bus without a clock edge
      i_readM = 1'b1; i_address = 16'h0020;
      repeat (L + 1) @(negedge Clk);
      #1;
      chk("ra_i_ack", i_ack, 1'b1);
      chk("ra_i_data", i_bus, 16'h1234);
      Reset_N = 1'b1;
      #1;
      chk("ra_i_ack_rst", i_ack, 1'b0);
      chk("ra_i_data_rst", i_bus, HIZ);
      i_readM = 1'b0;
      @(negedge Clk);
      Reset_N = 1'b0;
      @(negedge Clk);
      d_txn(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
